// File: rtl/front_panel_event_pkg.sv
// -----------------------------------------------------------------------------
// front_panel_event_pkg
// Shared definitions for the front-panel event controller: event type codes,
// status word and command word bit positions, and the per-switch FSM states.
// Optional feature macro used by the importing files:
//   FRONT_PANEL_EVENT_DURATION_EN - carry a 16-bit press duration per entry.
// -----------------------------------------------------------------------------
package front_panel_event_pkg;

    // Event type carried in each FIFO entry
    localparam logic EVT_SHORT = 1'b0;
    localparam logic EVT_LONG  = 1'b1;

    // Status word layout
    localparam int VALID_BIT = 31;
    localparam int OVF_BIT   = 30;
    localparam int COUNT_LSB = 27;
    localparam int TYPE_BIT  = 26;
    localparam int INDEX_LSB = 23;

    // GPIO_OUT command bits, qualified by csrStrobe
    localparam int POP_BIT     = 31;
    localparam int CLR_OVF_BIT = 30;

    // Width of the ms counter and of the reported duration
    localparam int DUR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_HELD,
        ST_WAIT_RELEASE
    } sw_state_t;

endpackage

// File: rtl/front_panel_switch_fsm.sv
// -----------------------------------------------------------------------------
// front_panel_switch_fsm
// Classifies one debounced switch into SHORT / LONG press events and holds a
// single pending event until the arbiter takes it.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   sw            - debounced switch level (1 = pressed)
//   tick          - shared 1 ms tick
//   clr           - arbiter has taken the pending event this cycle
//   pend_dur      - pending event duration in ms (FRONT_PANEL_EVENT_DURATION_EN only)
//   pending       - an event is waiting for the arbiter
//   pend_type     - type of the pending event (EVT_SHORT / EVT_LONG)
//   ovf_event     - a new event overwrote a pending one that was not taken
// Optional feature macro: FRONT_PANEL_EVENT_DURATION_EN.
// LONG_PRESS_MS must fit in DUR_W bits.
// -----------------------------------------------------------------------------
module front_panel_switch_fsm
    import front_panel_event_pkg::*;
#(
    parameter int LONG_PRESS_MS = 2000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sw,
    input  logic             tick,
    input  logic             clr,
`ifdef FRONT_PANEL_EVENT_DURATION_EN
    output logic [DUR_W-1:0] pend_dur,
`endif
    output logic             pending,
    output logic             pend_type,
    output logic             ovf_event
);

    sw_state_t        state, state_next;
    logic [DUR_W-1:0] cnt, cnt_next, cnt_inc;
    logic             evt;
    logic             evt_type;

    // Saturating increment: the ms counter never wraps.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    // An event arriving while the previous one is still waiting (and not being
    // taken this very cycle) replaces it, so the old one is lost.
    assign ovf_event = evt & pending & ~clr;

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned; that is what keeps this combinational (no latch).
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        evt        = 1'b0;
        evt_type   = EVT_SHORT;
        case (state)
            ST_IDLE: begin
                if (sw) begin
                    state_next = ST_PRESSED;
                    cnt_next   = '0;
                end
            end
            ST_PRESSED: begin
                // Release takes priority over a tick arriving in the same cycle.
                if (!sw) begin
                    evt        = 1'b1;
                    evt_type   = EVT_SHORT;
                    state_next = ST_IDLE;
                end else if (tick) begin
                    cnt_next = cnt_inc;
                    if (32'(cnt_inc) >= LONG_PRESS_MS) begin
                        evt        = 1'b1;
                        evt_type   = EVT_LONG;
                        state_next = ST_HELD;
                    end
                end
            end
            ST_HELD, ST_WAIT_RELEASE: begin
                if (!sw) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // A switch already down when reset releases must be let go first.
            state     <= sw ? ST_WAIT_RELEASE : ST_IDLE;
            cnt       <= '0;
            pending   <= 1'b0;
            pend_type <= EVT_SHORT;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (evt) begin
                pending   <= 1'b1;
                pend_type <= evt_type;
            end else if (clr) begin
                pending <= 1'b0;
            end
        end
    end

`ifdef FRONT_PANEL_EVENT_DURATION_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_dur <= '0;
        end else if (evt) begin
            pend_dur <= (evt_type == EVT_LONG) ? DUR_W'(LONG_PRESS_MS) : cnt;
        end
    end
`endif

endmodule

// File: rtl/front_panel_event_ctrl.sv
// -----------------------------------------------------------------------------
// front_panel_event_ctrl
// Turns debounced front-panel switch levels into SHORT/LONG press events,
// arbitrates them (lowest switch index first) into a small event FIFO and
// reports the FIFO head through a registered status word.
// Ports:
//   clk        - system clock
//   reset      - synchronous reset, active-high
//   switch_i   - debounced switch levels, 1 = pressed
//   csrStrobe  - single-cycle strobe qualifying GPIO_OUT
//   GPIO_OUT   - [31] pop head entry, [30] clear overflow
//   status     - [31] not empty, [30] overflow, [29:27] count, [26] head type,
//                [25:23] head switch index, [22:16] zero, [15:0] duration
// Optional feature macro: FRONT_PANEL_EVENT_DURATION_EN (duration in [15:0];
// when undefined the field reads 0 and no duration storage exists).
// FIFO_DEPTH: power of 2, at most 8. NSWITCH: 1..8.
// -----------------------------------------------------------------------------
module front_panel_event_ctrl
    import front_panel_event_pkg::*;
#(
    parameter int CLK_RATE      = 100000000,
    parameter int NSWITCH       = 2,
    parameter int LONG_PRESS_MS = 2000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NSWITCH-1:0] switch_i,
    input  logic               csrStrobe,
    input  logic [31:0]        GPIO_OUT,
    output logic [31:0]        status
);

    localparam int TICK_DIV = CLK_RATE / 1000;
    localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // ------------------------------------------------------------------ tick
    logic [PRESC_W-1:0] presc;
    logic               tick;

    assign tick = (presc == PRESC_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // ------------------------------------------------------- switch FSMs
    logic [NSWITCH-1:0] pending;
    logic [NSWITCH-1:0] pend_type;
    logic [NSWITCH-1:0] fsm_ovf;
    logic [NSWITCH-1:0] grant;
`ifdef FRONT_PANEL_EVENT_DURATION_EN
    logic [DUR_W-1:0]   pend_dur [NSWITCH];
`endif

    for (genvar g = 0; g < NSWITCH; g++) begin : g_sw
        front_panel_switch_fsm #(
            .LONG_PRESS_MS(LONG_PRESS_MS)
        ) u_fsm (
            .clk      (clk),
            .reset    (reset),
            .sw       (switch_i[g]),
            .tick     (tick),
            .clr      (grant[g]),
`ifdef FRONT_PANEL_EVENT_DURATION_EN
            .pend_dur (pend_dur[g]),
`endif
            .pending  (pending[g]),
            .pend_type(pend_type[g]),
            .ovf_event(fsm_ovf[g])
        );
    end

    // ----------------------------------------------------------- arbiter
    logic             push;
    logic             push_type;
    logic [2:0]       push_idx;
`ifdef FRONT_PANEL_EVENT_DURATION_EN
    logic [DUR_W-1:0] push_dur;
`endif

    // Fixed priority: lowest pending index wins; the grant clears its flag
    // whether or not the FIFO can accept the entry.
    always_comb begin
        grant     = '0;
        push      = 1'b0;
        push_type = EVT_SHORT;
        push_idx  = '0;
`ifdef FRONT_PANEL_EVENT_DURATION_EN
        push_dur  = '0;
`endif
        for (int i = 0; i < NSWITCH; i++) begin
            if (pending[i] && !push) begin
                grant[i]  = 1'b1;
                push      = 1'b1;
                push_type = pend_type[i];
                push_idx  = 3'(i);
`ifdef FRONT_PANEL_EVENT_DURATION_EN
                push_dur  = pend_dur[i];
`endif
            end
        end
    end

    // -------------------------------------------------------------- FIFO
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [3:0]       count;
    logic             fifo_type [FIFO_DEPTH];
    logic [2:0]       fifo_idx  [FIFO_DEPTH];
`ifdef FRONT_PANEL_EVENT_DURATION_EN
    logic [DUR_W-1:0] fifo_dur  [FIFO_DEPTH];
`endif
    logic             empty, full;
    logic             pop_fire, push_fire, drop, clr_ovf, ovf_set, ovf;
    logic             unused_gpio;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign unused_gpio = ^GPIO_OUT[29:0];

    assign empty     = (count == 4'd0);
    assign full      = (count == 4'(FIFO_DEPTH));
    assign pop_fire  = csrStrobe & GPIO_OUT[POP_BIT] & ~empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign push_fire = push & (~full | pop_fire);
    assign drop      = push & full & ~pop_fire;
    assign clr_ovf   = csrStrobe & GPIO_OUT[CLR_OVF_BIT];
    assign ovf_set   = drop | (|fsm_ovf);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_fire) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_fire)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_fire, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new overflow in the same cycle as a clear wins.
            if (ovf_set)      ovf <= 1'b1;
            else if (clr_ovf) ovf <= 1'b0;
        end
    end

    // NOTE: entry storage has no reset; contents are only ever read under a
    // non-zero count, and leaving it unreset lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            fifo_type[wr_ptr] <= push_type;
            fifo_idx[wr_ptr]  <= push_idx;
`ifdef FRONT_PANEL_EVENT_DURATION_EN
            fifo_dur[wr_ptr]  <= push_dur;
`endif
        end
    end

    // ------------------------------------------------------------ status
    logic [31:0] status_next;

    always_comb begin
        status_next                   = '0;
        status_next[VALID_BIT]        = ~empty;
        status_next[OVF_BIT]          = ovf;
        // Count of 8 reads back as 0 in the 3-bit field; VALID tells it apart.
        status_next[COUNT_LSB +: 3]   = count[2:0];
        if (!empty) begin
            status_next[TYPE_BIT]       = fifo_type[rd_ptr];
            status_next[INDEX_LSB +: 3] = fifo_idx[rd_ptr];
`ifdef FRONT_PANEL_EVENT_DURATION_EN
            status_next[DUR_W-1:0]      = fifo_dur[rd_ptr];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            status <= '0;
        end else begin
            status <= status_next;
        end
    end

endmodule
